// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one combinational 32-bit barrel shifter between two
// valid/ready requesters, with a single result register and per-port response valid.

module shift_arbiter_shifter #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [DATA_W-1:0]  a,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               dir,
  input  logic               arith,
  output logic [DATA_W-1:0]  out
);

  logic                fill;
  logic [DATA_W-1:0]   stage;
  logic [DATA_W-1:0]   fill_mask;

  assign fill = arith & dir & a[DATA_W-1];

  // Log-depth shifter: stage k shifts by 2**k when shamt[k] is set.
  always_comb begin
    stage     = a;
    fill_mask = {DATA_W{1'b0}};
    for (int k = 0; k < SHAMT_W; k++) begin
      if (shamt[k]) begin
        if (dir) begin
          if (fill) begin
            fill_mask = ~({DATA_W{1'b1}} >> (1 << k));
          end else begin
            fill_mask = {DATA_W{1'b0}};
          end
          stage = (stage >> (1 << k)) | fill_mask;
        end else begin
          stage = stage << (1 << k);
        end
      end else begin
        stage = stage;
      end
    end
  end

  assign out = stage;

endmodule

module shift_arbiter #(
  parameter int   DATA_W  = 32,
  parameter int   SHAMT_W = 5,
  parameter logic RR_INIT = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [2*DATA_W-1:0]   req_data,
  input  logic [2*SHAMT_W-1:0]  req_shamt,
  input  logic [1:0]            req_dir,
  input  logic [1:0]            req_arith,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]         state;
  logic               owner;
  logic               last_grant;
  logic [DATA_W-1:0]  result;

  logic               eligible;
  logic               grant_any;
  logic               grant_port;
  logic [1:0]         grant;

  logic [DATA_W-1:0]  sel_a;
  logic [SHAMT_W-1:0] sel_shamt;
  logic               sel_dir;
  logic               sel_arith;
  logic [DATA_W-1:0]  shift_out;

  // A HOLD slot may be refilled in the same cycle its owner drains it.
  always_comb begin
    eligible   = 1'b0;
    grant_any  = 1'b0;
    grant_port = last_grant;
    if ((state == IDLE) || ((state == HOLD) && rsp_ready[owner])) begin
      eligible = 1'b1;
    end else begin
      eligible = 1'b0;
    end
    if (eligible) begin
      case (req_valid)
        2'b01: begin
          grant_any  = 1'b1;
          grant_port = 1'b0;
        end
        2'b10: begin
          grant_any  = 1'b1;
          grant_port = 1'b1;
        end
        2'b11: begin
          grant_any  = 1'b1;
          grant_port = ~last_grant;
        end
        default: begin
          grant_any  = 1'b0;
          grant_port = last_grant;
        end
      endcase
    end else begin
      grant_any  = 1'b0;
      grant_port = last_grant;
    end
  end

  // Steer the winning port's operand fields into the shared shifter.
  always_comb begin
    grant     = 2'b00;
    sel_a     = req_data[DATA_W-1:0];
    sel_shamt = req_shamt[SHAMT_W-1:0];
    sel_dir   = req_dir[0];
    sel_arith = req_arith[0];
    if (grant_port) begin
      sel_a     = req_data[2*DATA_W-1:DATA_W];
      sel_shamt = req_shamt[2*SHAMT_W-1:SHAMT_W];
      sel_dir   = req_dir[1];
      sel_arith = req_arith[1];
    end else begin
      sel_a     = req_data[DATA_W-1:0];
      sel_shamt = req_shamt[SHAMT_W-1:0];
      sel_dir   = req_dir[0];
      sel_arith = req_arith[0];
    end
    if (grant_any) begin
      grant = grant_port ? 2'b10 : 2'b01;
    end else begin
      grant = 2'b00;
    end
  end

  shift_arbiter_shifter #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .a     (sel_a),
    .shamt (sel_shamt),
    .dir   (sel_dir),
    .arith (sel_arith & sel_dir),
    .out   (shift_out)
  );

  // Result register and round-robin pointer; a consume without refill keeps rsp_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= RR_INIT;
      result     <= {DATA_W{1'b0}};
    end else begin
      if (grant_any) begin
        state      <= HOLD;
        owner      <= grant_port;
        last_grant <= grant_port;
        result     <= shift_out;
      end else if ((state == HOLD) && rsp_ready[owner]) begin
        state <= IDLE;
      end else begin
        state <= state;
      end
    end
  end

  assign req_ready = grant;
  assign rsp_valid = (state == HOLD) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data  = result;
  assign busy      = (state == HOLD);

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed and randomized self-checking bench for shift_arbiter.

module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_data;
  logic [9:0]  req_shamt;
  logic [1:0]  req_dir;
  logic [1:0]  req_arith;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  always #5 clk = ~clk;

  shift_arbiter #(.DATA_W(32), .SHAMT_W(5), .RR_INIT(1'b0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_shamt (req_shamt),
    .req_dir   (req_dir),
    .req_arith (req_arith),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] s,
                                            input logic dir, input logic arith);
    logic signed [31:0] sa;
    sa = a;
    if (!dir) return a << s;
    else if (arith) return sa >>> s;
    else return a >> s;
  endfunction

  task automatic set_req(input int p, input logic [31:0] a, input logic [4:0] s,
                         input logic dir, input logic arith);
    req_valid[p]         = 1'b1;
    req_data[32*p +: 32] = a;
    req_shamt[5*p +: 5]  = s;
    req_dir[p]           = dir;
    req_arith[p]         = arith;
  endtask

  // Entered just after a rising edge with the DUT idle.
  task automatic single_op(input string tag, input int p, input logic [31:0] a, input logic [4:0] s,
                           input logic dir, input logic arith, input logic [31:0] exp);
    rsp_ready = 2'b00;
    set_req(p, a, s, dir, arith);
    @(negedge clk);
    check({tag, "_ready"}, {30'd0, req_ready}, (p == 1) ? 32'd2 : 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    check({tag, "_valid"}, {30'd0, rsp_valid}, (p == 1) ? 32'd2 : 32'd1);
    check({tag, "_data"}, rsp_data, exp);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    rsp_ready = 2'b11;
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    check({tag, "_drained"}, {30'd0, rsp_valid}, 32'd0);
    check({tag, "_retain"}, rsp_data, exp);
  endtask

  // Scoreboard one cycle, sampled at the falling edge.
  task automatic sb_cycle(output logic [1:0] acc);
    acc = req_valid & req_ready;
    check("t6_ready_only_valid", {30'd0, req_ready & ~req_valid}, 32'd0);
    check("t6_rsp_onehot", {31'd0, (rsp_valid == 2'b11)}, 32'd0);
    if (acc[0]) q0.push_back(ref_shift(req_data[31:0], req_shamt[4:0], req_dir[0], req_arith[0]));
    if (acc[1]) q1.push_back(ref_shift(req_data[63:32], req_shamt[9:5], req_dir[1], req_arith[1]));
    if (rsp_valid[0] && rsp_ready[0]) begin
      check("t6_p0_expected", {31'd0, (q0.size() > 0)}, 32'd1);
      if (q0.size() > 0) check("t6_p0_data", rsp_data, q0.pop_front());
    end
    if (rsp_valid[1] && rsp_ready[1]) begin
      check("t6_p1_expected", {31'd0, (q1.size() > 0)}, 32'd1);
      if (q1.size() > 0) check("t6_p1_data", rsp_data, q1.pop_front());
    end
  endtask

  initial begin
    logic [1:0] acc;
    int issued;
    int cyc;
    rst_n     = 1'b1;
    req_valid = 2'b00;
    req_data  = 64'd0;
    req_shamt = 10'd0;
    req_dir   = 2'b00;
    req_arith = 2'b00;
    rsp_ready = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    check("rst_req_ready", {30'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    single_op("t2_asr4", 0, 32'h8000_00F0, 5'd4, 1'b1, 1'b1, 32'hF800_000F);
    single_op("t3_shl31", 1, 32'h8000_0001, 5'd31, 1'b0, 1'b0, 32'h8000_0000);
    single_op("t3_shr31", 1, 32'h8000_0001, 5'd31, 1'b1, 1'b0, 32'h0000_0001);
    single_op("t3_asr31", 1, 32'h8000_0001, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF);
    single_op("t3_sh0", 1, 32'h8000_0001, 5'd0, 1'b1, 1'b1, 32'h8000_0001);
    single_op("t3_shl_arith", 1, 32'h8000_0001, 5'd1, 1'b0, 1'b1, 32'h0000_0002);

    // T1: reset while a result is held
    set_req(0, 32'h1234_5678, 5'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    check("t1_pre_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_async_valid", {30'd0, rsp_valid}, 32'd0);
    check("t1_async_busy", {31'd0, busy}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("t1_no_pulse", {30'd0, rsp_valid}, 32'd0);

    // T4: continuous contention, first tie goes to port 1
    set_req(0, 32'd1, 5'd1, 1'b0, 1'b0);
    set_req(1, 32'd1, 5'd2, 1'b0, 1'b0);
    rsp_ready = 2'b11;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t4_ready", {30'd0, req_ready}, (i % 2 == 0) ? 32'd2 : 32'd1);
      @(posedge clk); #1;
      check("t4_valid", {30'd0, rsp_valid}, (i % 2 == 0) ? 32'd2 : 32'd1);
      check("t4_data", rsp_data, (i % 2 == 0) ? 32'd4 : 32'd2);
    end
    req_valid = 2'b00;
    @(posedge clk); #1;
    check("t4_drain", {30'd0, rsp_valid}, 32'd0);

    // T5: backpressure on the owner, non-owner rsp_ready ignored
    rsp_ready = 2'b00;
    set_req(0, 32'h0000_00FF, 5'd8, 1'b0, 1'b0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    set_req(1, 32'h1234_5678, 5'd4, 1'b1, 1'b0);
    rsp_ready = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_ready_blocked", {30'd0, req_ready}, 32'd0);
      check("t5_valid", {30'd0, rsp_valid}, 32'd1);
      check("t5_data_stable", rsp_data, 32'h0000_FF00);
      @(posedge clk); #1;
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    check("t5_refill_ready", {30'd0, req_ready}, 32'd2);
    @(posedge clk); #1;
    req_valid = 2'b00;
    check("t5_refill_valid", {30'd0, rsp_valid}, 32'd2);
    check("t5_refill_data", rsp_data, 32'h0123_4567);
    rsp_ready = 2'b11;
    @(posedge clk); #1;

    // T6: random traffic against the reference model
    issued = 0;
    cyc    = 0;
    rsp_ready = 2'b00;
    while (issued < 10000 && cyc < 60000) begin
      @(negedge clk);
      sb_cycle(acc);
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (acc[p] || !req_valid[p]) begin
          if (issued < 10000 && $urandom_range(0, 3) != 0) begin
            set_req(p, $urandom(), 5'($urandom_range(0, 31)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            issued++;
          end else begin
            req_valid[p] = 1'b0;
          end
        end
      end
      rsp_ready = 2'($urandom_range(0, 3));
      cyc++;
    end
    check("t6_budget", {31'd0, (issued >= 10000)}, 32'd1);
    cyc = 0;
    while ((req_valid != 2'b00 || rsp_valid != 2'b00 || q0.size() > 0 || q1.size() > 0) && cyc < 200) begin
      @(negedge clk);
      sb_cycle(acc);
      @(posedge clk); #1;
      req_valid = req_valid & ~acc;
      rsp_ready = 2'b11;
      cyc++;
    end
    check("t6_q0_empty", q0.size(), 32'd0);
    check("t6_q1_empty", q1.size(), 32'd0);
    check("t6_idle_end", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
